// File: rtl/c1541_head_stepper.sv
// C1541 head stepper: turns VIA stepper phases into a half-track index,
// tracks head settle time and requests write-back of a dirty track buffer.
module c1541_head_stepper #(
   parameter int RESET_HT   = 36,
   parameter int MAX_HT     = 84,
   parameter int SETTLE_CYC = 3000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ce,
   input  logic [1:0] stp,
   input  logic       mtr,
   input  logic       act,
   input  logic       we,
   input  logic       img_mounted,
   output logic [6:0] half_track,
   output logic       tr00_sense_n,
   output logic       save_track,
   output logic       settling,
   output logic       modified
);

   localparam int SW = $clog2(SETTLE_CYC + 1);

   logic [1:0]    stp_old;
   logic [1:0]    delta;
   logic          step_in;
   logic          step_out;
   logic          attempt;
   logic          moved;
   logic          wr;
   logic          mnt_q;
   logic          mnt_rise;
   logic          flush;
   logic [SW-1:0] settle_cnt;
   logic          save_r = 1'b0;

   // Phase difference against the last sampled phase, wrap-around mod 4.
   always_comb begin
      delta    = stp - stp_old;
      step_in  = ce & mtr & (delta == 2'd1);
      step_out = ce & mtr & (delta == 2'd3);
      attempt  = step_in | step_out;
      moved    = (step_in  & (half_track != 7'(MAX_HT))) |
                 (step_out & (half_track != 7'd0));
      wr       = we & ce;
      mnt_rise = img_mounted & ~mnt_q;
      flush    = modified & (attempt | ~act);
   end

   // Head position, phase history and mount edge register.
   always_ff @(posedge clk) begin
      if (reset) begin
         half_track <= 7'(RESET_HT);
         stp_old    <= stp;
         mnt_q      <= img_mounted;
      end else begin
         if (ce)
            stp_old <= stp;
         mnt_q <= img_mounted;
         if (moved && step_in)
            half_track <= half_track + 7'd1;
         else if (moved && step_out)
            half_track <= half_track - 7'd1;
      end
   end

   // Settle timer: reloaded only by a step that actually moved the head.
   always_ff @(posedge clk) begin
      if (reset)
         settle_cnt <= '0;
      else if (moved)
         settle_cnt <= SW'(SETTLE_CYC);
      else if (ce && settle_cnt != '0)
         settle_cnt <= settle_cnt - 1'b1;
   end

   // Dirty flag and write-back toggle; a new mount discards dirty state.
   always_ff @(posedge clk) begin
      if (reset) begin
         modified <= 1'b0;
      end else if (mnt_rise) begin
         modified <= 1'b0;
      end else if (flush) begin
         save_r   <= ~save_r;
         modified <= wr;
      end else if (wr) begin
         modified <= 1'b1;
      end
   end

   assign save_track   = save_r;
   assign settling     = (settle_cnt != '0);
   assign tr00_sense_n = |half_track;

endmodule

// File: tb/tb_c1541_head_stepper.sv
// Self-checking bench for c1541_head_stepper: directed scenarios plus
// randomized stimulus against an integer-level reference model.
module tb_c1541_head_stepper;

   localparam int RHT = 36;
   localparam int MHT = 84;
   localparam int SC  = 3000;

   logic       clk = 1'b0;
   logic       reset;
   logic       ce;
   logic [1:0] stp;
   logic       mtr;
   logic       act;
   logic       we;
   logic       img_mounted;
   logic [6:0] half_track;
   logic       tr00_sense_n;
   logic       save_track;
   logic       settling;
   logic       modified;

   int checks = 0;
   int errors = 0;

   int m_ht;
   int m_settle;
   bit m_mod;
   bit m_save = 1'b0;
   int m_old;
   bit m_mnt;

   c1541_head_stepper dut (
      .clk(clk),
      .reset(reset),
      .ce(ce),
      .stp(stp),
      .mtr(mtr),
      .act(act),
      .we(we),
      .img_mounted(img_mounted),
      .half_track(half_track),
      .tr00_sense_n(tr00_sense_n),
      .save_track(save_track),
      .settling(settling),
      .modified(modified)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
      end
   endtask

   // Reference model: one clock edge of behaviour from the current inputs.
   task automatic model_step();
      int d, dir, nht;
      bit tried, wr;
      if (reset) begin
         m_ht = RHT; m_mod = 0; m_settle = 0;
         m_old = int'(stp); m_mnt = img_mounted;
         return;
      end
      dir = 0;
      if (ce && mtr) begin
         d = (int'(stp) + 4 - m_old) % 4;
         if (d == 1) dir = 1;
         if (d == 3) dir = -1;
      end
      tried = (dir != 0);
      nht = m_ht + dir;
      if (nht < 0) nht = 0;
      if (nht > MHT) nht = MHT;
      if (nht != m_ht) m_settle = SC;
      else if (ce && m_settle > 0) m_settle--;
      wr = we && ce;
      if (img_mounted && !m_mnt) m_mod = 0;
      else if (m_mod && (tried || !act)) begin
         m_save = !m_save;
         m_mod = wr;
      end else if (wr) m_mod = 1;
      if (ce) m_old = int'(stp);
      m_mnt = img_mounted;
      m_ht = nht;
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      chk("half_track", int'(half_track), m_ht);
      chk("tr00_sense_n", int'(tr00_sense_n), int'(m_ht != 0));
      chk("save_track", int'(save_track), int'(m_save));
      chk("settling", int'(settling), int'(m_settle > 0));
      chk("modified", int'(modified), int'(m_mod));
   endtask

   task automatic idle(input int n);
      ce = 1; we = 0;
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic step(input int dir);
      stp = stp + 2'(dir); ce = 1; we = 0;
      tick();
   endtask

   task automatic write1();
      we = 1; ce = 1;
      tick();
      we = 0;
   endtask

   initial begin
      bit sv;
      int ht0;
      reset = 1; ce = 0; stp = 0; mtr = 1; act = 1; we = 0; img_mounted = 0;
      tick();
      tick();
      chk("reset_ht", int'(half_track), 36);
      chk("reset_settle", int'(settling), 0);
      chk("reset_mod", int'(modified), 0);
      reset = 0;
      tick();

      // Four step-ins with full settle intervals.
      for (int k = 1; k <= 4; k++) begin
         step(1);
         chk("seq_ht", int'(half_track), 36 + k);
         chk("seq_settle_on", int'(settling), 1);
         idle(SC - 1);
         chk("seq_settle_last", int'(settling), 1);
         idle(1);
         chk("seq_settle_off", int'(settling), 0);
      end
      chk("seq_stp_wrapped", int'(stp), 0);

      // Walk to track 0, let it settle, then dirty step-out at the stop.
      for (int k = 0; k < 45; k++) step(-1);
      chk("walk_ht0", int'(half_track), 0);
      idle(SC);
      write1();
      chk("out_mod_set", int'(modified), 1);
      sv = save_track;
      step(-1);
      chk("out_clamp_ht", int'(half_track), 0);
      chk("out_tr00", int'(tr00_sense_n), 0);
      chk("out_save_tgl", int'(save_track), int'(!sv));
      chk("out_mod_clr", int'(modified), 0);
      chk("out_no_settle", int'(settling), 0);

      // Motor off: phase tracked but no movement, no phantom later.
      ht0 = int'(half_track);
      mtr = 0;
      step(1);
      chk("mtr0_hold", int'(half_track), ht0);
      mtr = 1;
      step(1);
      chk("mtr1_move", int'(half_track), ht0 + 1);

      // Two-phase jump is ignored and does not flush.
      idle(SC);
      write1();
      sv = save_track;
      ht0 = int'(half_track);
      step(2);
      chk("jump_hold", int'(half_track), ht0);
      chk("jump_noflush", int'(save_track), int'(sv));
      chk("jump_mod", int'(modified), 1);

      // Idle flush on the first act=0 cycle only.
      idle(3);
      chk("act1_nosave", int'(save_track), int'(sv));
      act = 0;
      idle(1);
      chk("idle_flush", int'(save_track), int'(!sv));
      chk("idle_mod_clr", int'(modified), 0);
      idle(2);
      chk("idle_once", int'(save_track), int'(!sv));
      act = 1;

      // Mount edge with a step: moves, discards dirty state silently.
      write1();
      sv = save_track;
      ht0 = int'(half_track);
      img_mounted = 1;
      step(1);
      chk("mnt_move", int'(half_track), ht0 + 1);
      chk("mnt_nosave", int'(save_track), int'(sv));
      chk("mnt_mod_clr", int'(modified), 0);

      // Upper stop: clamped attempt does not reload the settle timer.
      for (int k = int'(half_track); k < MHT; k++) step(1);
      chk("top_ht", int'(half_track), MHT);
      idle(SC);
      step(1);
      chk("top_clamp", int'(half_track), MHT);
      chk("top_no_settle", int'(settling), 0);

      // Reset mid-settle keeps save_track.
      step(-1);
      sv = save_track;
      reset = 1;
      tick();
      chk("rst_ht", int'(half_track), RHT);
      chk("rst_settle", int'(settling), 0);
      chk("rst_save_hold", int'(save_track), int'(sv));
      reset = 0;

      // Randomized traffic.
      for (int i = 0; i < 20000; i++) begin
         ce  = ($urandom_range(0, 3) == 0);
         mtr = ($urandom_range(0, 4) != 0);
         act = ($urandom_range(0, 2) != 0);
         we  = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 30) == 0) stp = 2'($urandom);
         if ($urandom_range(0, 300) == 0) img_mounted = ~img_mounted;
         reset = ($urandom_range(0, 4000) == 0);
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/c1541_head_stepper.md
C1541_HEAD_STEPPER -- requirements
Module: c1541_head_stepper

Interface
REQ-001 SHALL provide parameter RESET_HT, default 36, half-track index after reset.
REQ-002 SHALL provide parameter MAX_HT, default 84, highest legal half-track index.
REQ-003 SHALL provide parameter SETTLE_CYC, default 3000, ce ticks of head-settle time after a step.
REQ-004 SHALL have port clk  in  1  drive clock (16 MHz); sole clock.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port ce  in  1  drive clock-enable (1 MHz tick).
REQ-007 SHALL have port stp  in  2  stepper phase from drive logic VIA.
REQ-008 SHALL have port mtr  in  1  spindle motor on.
REQ-009 SHALL have port act  in  1  drive activity (LED) from drive logic.
REQ-010 SHALL have port we  in  1  GCR track-buffer write strobe.
REQ-011 SHALL have port img_mounted  in  1  image mount pulse/level.
REQ-012 SHALL have port half_track  out  7  current head half-track index.
REQ-013 SHALL have port tr00_sense_n  out  1  low when head at half-track 0.
REQ-014 SHALL have port save_track  out  1  toggle requesting write-back of current track.
REQ-015 SHALL have port settling  out  1  high while head settles after a step.
REQ-016 SHALL have port modified  out  1  current track holds unsaved writes.

Function
REQ-017 SHALL sample stp only on cycles with ce=1, keeping stp_old as the previous sampled value.
REQ-018 SHALL compute delta = (stp - stp_old) mod 4, 2-bit wrap-around arithmetic.
REQ-019 SHALL treat delta=1 as step-in (+1), delta=3 as step-out (-1), delta 0 or 2 as no step.
REQ-020 SHALL act on a step only when mtr=1; stp_old SHALL update on every ce regardless of mtr.
REQ-021 SHALL update half_track on the clk edge following the ce sample that detects the step (1-cycle latency).
REQ-022 SHALL clamp: step-in at MAX_HT and step-out at 0 leave half_track unchanged, still count as step attempts.
REQ-023 SHALL load the settle counter with SETTLE_CYC on every step that changes half_track and decrement it on ce while nonzero.
REQ-024 SHALL drive settling = (settle counter != 0); a clamped attempt SHALL NOT reload the counter.
REQ-025 SHALL set modified when we=1 and ce=1.
REQ-026 SHALL on any step attempt with modified=1 toggle save_track once and clear modified.
REQ-027 SHALL when modified=1, act=0 and no step attempt toggle save_track once and clear modified (idle flush).
REQ-028 SHALL produce at most one save_track toggle per clk cycle.
REQ-029 SHALL when a write (we&ce) coincides with a flush still toggle save_track and leave modified=1.
REQ-030 SHALL detect the rising edge of img_mounted and clear modified without toggling save_track, overriding REQ-025..REQ-029 that cycle.
REQ-031 SHALL drive tr00_sense_n = OR of half_track bits, combinationally.

Reset
REQ-032 SHALL on reset=1 set half_track=RESET_HT, modified=0, settle counter=0, stp_old=stp, img_mounted edge register=img_mounted.
REQ-033 SHALL hold save_track at its current value through reset (no toggle), initialised to 0 at configuration.
REQ-034 SHALL take precedence over all function rules when reset=1 mid-step or mid-settle.

Verification
REQ-035 SHALL cover: reset, mtr=1, stp 0->1->2->3->0 on ce -> half_track 36,37,38,39,40; settling high 3000 ce after each step.
REQ-036 SHALL cover: half_track=0, stp stepping out, we pulsed first -> half_track stays 0, tr00_sense_n=0, save_track toggles once, settling stays 0.
REQ-037 SHALL cover: mtr=0, stp 0->1 -> half_track unchanged; then mtr=1, stp 1->2 -> half_track +1 (no phantom step).
REQ-038 SHALL cover: stp 0->2 jump -> no movement, no flush.
REQ-039 SHALL cover: we&ce, act=1 then act=0 -> save_track toggles exactly once on first act=0 cycle, modified=0.
REQ-040 SHALL cover: modified=1, img_mounted rises together with step -> half_track moves, save_track unchanged, modified=0.
